// File: rtl/noc_inject_arbiter.sv
// noc_inject_arbiter: round-robin arbiter sharing one NoC local injection port
// among NumPorts valid/ready requesters, driving the NoC avail/valid handshake.
// Optional feature macro: NOC_ARB_PACKET_LOCK_EN -- when defined, the grant is
// held until the tail flit of a packet; when undefined, every accepted flit
// ends the grant and arbitration runs per flit.
module noc_inject_arbiter #(
  parameter int unsigned NumPorts  = 4,
  parameter int unsigned DataWidth = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NumPorts*DataWidth-1:0] req_data_i,
  input  logic [NumPorts-1:0]           req_valid_i,
  input  logic [NumPorts-1:0]           req_last_i,
  output logic [NumPorts-1:0]           req_ready_o,
  output logic [DataWidth-1:0]          data_o,
  output logic                          data_valid_o,
  input  logic                          avail_i,
  output logic [NumPorts-1:0]           grant_o
);

  localparam int unsigned PtrWidth = (NumPorts > 1) ? $clog2(NumPorts) : 1;

  typedef enum logic {
    StIdle   = 1'b0,
    StLocked = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [PtrWidth-1:0]   owner_q, owner_d;
  logic [PtrWidth-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NumPorts-1:0]   grant_q, grant_d;
  logic                  avail_q;
  logic [DataWidth-1:0]  data_q, data_d;
  logic                  data_valid_q, data_valid_d;

  logic [NumPorts-1:0]   upper_mask;
  logic [NumPorts-1:0]   upper_req;
  logic [PtrWidth-1:0]   winner;
  logic [NumPorts-1:0]   winner_oh;
  logic [DataWidth-1:0]  owner_data;
  logic                  xfer;
  logic                  pkt_end;
  logic [PtrWidth-1:0]   rr_next;

  // Round-robin pick: lowest requester at or above rr_ptr, else lowest overall.
  always_comb begin
    upper_mask = '0;
    for (int i = 0; i < int'(NumPorts); i++) begin
      upper_mask[i] = (int'(rr_ptr_q) <= i);
    end
    upper_req = req_valid_i & upper_mask;
    winner    = '0;
    winner_oh = '0;
    for (int i = int'(NumPorts) - 1; i >= 0; i--) begin
      if (req_valid_i[i]) begin
        winner       = PtrWidth'(i);
        winner_oh    = '0;
        winner_oh[i] = 1'b1;
      end
    end
    for (int i = int'(NumPorts) - 1; i >= 0; i--) begin
      if (upper_req[i]) begin
        winner       = PtrWidth'(i);
        winner_oh    = '0;
        winner_oh[i] = 1'b1;
      end
    end
  end

  // Only the owner may be ready, and only while the registered NoC avail is up.
  assign req_ready_o = ((state_q == StLocked) && avail_q) ? grant_q : '0;
  assign xfer        = |(req_valid_i & req_ready_o);

  // AND-OR mux of the owner's flit, selected by the one-hot grant.
  always_comb begin
    owner_data = '0;
    for (int k = 0; k < int'(NumPorts); k++) begin
      owner_data = owner_data |
                   (req_data_i[k*DataWidth +: DataWidth] & {DataWidth{grant_q[k]}});
    end
  end

`ifdef NOC_ARB_PACKET_LOCK_EN
  // Grant ends only on the accepted tail flit.
  assign pkt_end = xfer && |(req_last_i & grant_q);
`else
  // Every accepted flit ends the grant; the tail flag has no role.
  logic unused_last;
  assign unused_last = ^req_last_i;
  assign pkt_end     = xfer;
`endif

  // Explicit wrap so non-power-of-two port counts return to port 0.
  assign rr_next = (owner_q == PtrWidth'(NumPorts - 1)) ? '0 : owner_q + PtrWidth'(1);

  // Next-state and output-register logic.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    if (xfer) begin
      data_valid_d = 1'b1;
      data_d       = owner_data;
    end
    case (state_q)
      StIdle: begin
        if (|req_valid_i) begin
          state_d = StLocked;
          owner_d = winner;
          grant_d = winner_oh;
        end
      end
      StLocked: begin
        if (pkt_end) begin
          state_d  = StIdle;
          grant_d  = '0;
          rr_ptr_d = rr_next;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      avail_q      <= 1'b0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      avail_q      <= avail_i;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign data_o       = data_q;
  assign data_valid_o = data_valid_q;
  assign grant_o      = grant_q;

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// tb_noc_inject_arbiter: randomized and directed bench for noc_inject_arbiter
// with a transaction-level reference model (owner index, round-robin pointer).
module tb_noc_inject_arbiter;

  localparam int NP = 4;
  localparam int DW = 64;
`ifdef NOC_ARB_PACKET_LOCK_EN
  localparam bit LockEn = 1'b1;
`else
  localparam bit LockEn = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NP*DW-1:0]  req_data_i;
  logic [NP-1:0]     req_valid_i;
  logic [NP-1:0]     req_last_i;
  logic [NP-1:0]     req_ready_o;
  logic [DW-1:0]     data_o;
  logic              data_valid_o;
  logic              avail_i;
  logic [NP-1:0]     grant_o;

  noc_inject_arbiter #(.NumPorts(NP), .DataWidth(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_data_i   (req_data_i),
    .req_valid_i  (req_valid_i),
    .req_last_i   (req_last_i),
    .req_ready_o  (req_ready_o),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .avail_i      (avail_i),
    .grant_o      (grant_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Requester-side flit queues and per-port record of everything sent.
  logic [DW-1:0] qd   [NP][$];
  bit            ql   [NP][$];
  logic [DW-1:0] sent [NP][$];
  bit            hold [NP];
  bit            avail_drv;
  logic [DW-1:0] out_d [$];
  int            out_c [$];
  logic [NP-1:0] rdy_obs, rdy_exp;

  // Reference model: owner = -1 means no grant.
  int            m_owner = -1;
  int            m_rr    = 0;
  bit            m_avail = 1'b0;
  bit            m_dv    = 1'b0;
  logic [DW-1:0] m_data  = '0;

  function automatic logic [NP-1:0] onehot(input int o);
    return (o >= 0) ? (NP'(1) << o) : '0;
  endfunction

  function automatic int port_of(input logic [DW-1:0] d);
    return int'(d[DW-1 -: 4]);
  endfunction

  function automatic int count_port(input int p);
    int n = 0;
    foreach (out_d[i]) if (port_of(out_d[i]) == p) n++;
    return n;
  endfunction

  function automatic logic [DW-1:0] mk(input int k);
    return {4'(k), 28'($urandom), 32'($urandom)};
  endfunction

  always @(posedge clk) begin : ref_model
    int  nxt;
    bit  xf;
    int  p;
    if (rst) begin
      m_owner <= -1;
      m_rr    <= 0;
      m_avail <= 1'b0;
      m_dv    <= 1'b0;
      m_data  <= '0;
    end else begin
      nxt = m_owner;
      xf  = (m_owner >= 0) && m_avail && req_valid_i[m_owner];
      m_dv <= xf;
      if (xf) m_data <= req_data_i[m_owner*DW +: DW];
      if (m_owner < 0) begin
        for (int i = 0; i < NP; i++) begin
          p = (m_rr + i) % NP;
          if (nxt < 0 && req_valid_i[p]) nxt = p;
        end
      end else if (xf && (req_last_i[m_owner] || !LockEn)) begin
        nxt = -1;
        m_rr <= (m_owner + 1) % NP;
      end
      m_owner <= nxt;
      m_avail <= avail_i;
    end
  end

  task automatic push_flit(input int k, input logic [DW-1:0] d, input bit last);
    qd[k].push_back(d);
    ql[k].push_back(last);
    sent[k].push_back(d);
  endtask

  // One clock: drive at negedge, sample ready mid-cycle, settle past posedge.
  task automatic step();
    logic [NP*DW-1:0] dat;
    logic [NP-1:0]    vld, lst, fire;
    @(negedge clk);
    for (int k = 0; k < NP; k++) begin
      if (!hold[k] && qd[k].size() > 0) begin
        vld[k] = 1'b1;
        dat[k*DW +: DW] = qd[k][0];
        lst[k] = ql[k][0];
      end else begin
        vld[k] = 1'b0;
        dat[k*DW +: DW] = {$urandom, $urandom};
        lst[k] = 1'($urandom_range(0, 1));
      end
    end
    req_valid_i = vld;
    req_data_i  = dat;
    req_last_i  = lst;
    avail_i     = avail_drv;
    #1;
    rdy_obs = req_ready_o;
    rdy_exp = m_avail ? onehot(m_owner) : '0;
    fire    = req_valid_i & req_ready_o;
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < NP; k++) begin
      if (fire[k] && qd[k].size() > 0) begin
        void'(qd[k].pop_front());
        void'(ql[k].pop_front());
      end
    end
    if (data_valid_o === 1'b1) begin
      out_d.push_back(data_o);
      out_c.push_back(cyc);
    end
  endtask

  task automatic do_reset();
    for (int k = 0; k < NP; k++) begin
      qd[k].delete(); ql[k].delete(); sent[k].delete(); hold[k] = 1'b0;
    end
    out_d.delete(); out_c.delete();
    avail_drv = 1'b1;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < NP; k++) begin
      qd[k].delete(); ql[k].delete(); sent[k].delete(); hold[k] = 1'b0;
      push_flit(k, DW'(k), 1'b1);
    end
    out_d.delete(); out_c.delete();
    avail_drv = 1'b1;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_tests++; if (data_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_dv: got %b want 0", data_valid_o); end
      n_tests++; if (data_o !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", data_o); end
      n_tests++; if (grant_o !== '0) begin n_fail++; $display("FAIL reset_grant: got %b want 0", grant_o); end
      n_tests++; if (req_ready_o !== '0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", req_ready_o); end
    end
    rst = 1'b0;
    step();
    n_tests++; if (grant_o !== 4'b0001) begin n_fail++; $display("FAIL first_grant: got %b want 0001", grant_o); end
    n_tests++; if (data_valid_o !== 1'b0) begin n_fail++; $display("FAIL idle_no_xfer: got %b want 0", data_valid_o); end
    step();
    n_tests++; if (rdy_obs !== 4'b0001) begin n_fail++; $display("FAIL first_ready: got %b want 0001", rdy_obs); end
    n_tests++; if (data_valid_o !== 1'b1 || data_o !== 64'd0) begin n_fail++; $display("FAIL first_flit: got dv=%b %h want dv=1 0", data_valid_o, data_o); end
  endtask

  task automatic test_fairness();
    int            order[$];
    logic [NP-1:0] prev_g;
    int            exp_order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < NP; k++) push_flit(k, DW'(k), 1'b1);
    prev_g = '0;
    for (int c = 0; c < 40; c++) begin
      step();
      n_tests++; if (grant_o !== onehot(m_owner)) begin n_fail++; $display("FAIL fair_grant: got %b want %b", grant_o, onehot(m_owner)); end
      n_tests++; if (data_valid_o !== m_dv || data_o !== m_data) begin n_fail++; $display("FAIL fair_out: got %b/%h want %b/%h", data_valid_o, data_o, m_dv, m_data); end
      n_tests++; if (rdy_obs !== rdy_exp) begin n_fail++; $display("FAIL fair_ready: got %b want %b", rdy_obs, rdy_exp); end
      if (grant_o !== '0 && prev_g === '0)
        for (int k = 0; k < NP; k++) if (grant_o[k]) order.push_back(k);
      prev_g = grant_o;
    end
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if ((i < order.size() ? order[i] : -1) != exp_order[i]) begin
        n_fail++; $display("FAIL fair_order[%0d]: got %0d want %0d", i, (i < order.size() ? order[i] : -1), exp_order[i]);
      end
    end
    n_tests++; if (out_d.size() != 12) begin n_fail++; $display("FAIL fair_count: got %0d want 12", out_d.size()); end
    for (int i = 0; i < out_d.size(); i++) begin
      n_tests++; if (out_d[i] !== DW'(i % NP)) begin n_fail++; $display("FAIL fair_payload[%0d]: got %h want %0d", i, out_d[i], i % NP); end
      if (i > 0) begin
        n_tests++; if (out_c[i] - out_c[i-1] != 2) begin n_fail++; $display("FAIL fair_spacing[%0d]: got %0d want 2", i, out_c[i] - out_c[i-1]); end
      end
    end
  endtask

  task automatic test_packet_lock();
    logic [DW-1:0] pk[4];
    int ord_l[4] = '{0, 1, 2, 3};
    int ord_n[4] = '{0, 3, 1, 2};
    int gap_l[3] = '{1, 1, 2};
    int gap_n[3] = '{2, 2, 2};
    logic [DW-1:0] got, want;
    do_reset();
    for (int i = 0; i < 3; i++) begin pk[i] = mk(2); push_flit(2, pk[i], i == 2); end
    pk[3] = mk(0);
    push_flit(0, pk[3], 1'b1);
    hold[0] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      n_tests++; if (grant_o !== onehot(m_owner)) begin n_fail++; $display("FAIL lock_grant: got %b want %b", grant_o, onehot(m_owner)); end
      if (grant_o === 4'b0100) hold[0] = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      got  = (i < out_d.size()) ? out_d[i] : 'x;
      want = pk[LockEn ? ord_l[i] : ord_n[i]];
      n_tests++; if (got !== want) begin n_fail++; $display("FAIL lock_seq[%0d]: got %h want %h", i, got, want); end
    end
    for (int i = 1; i < 4; i++) begin
      n_tests++;
      if ((i < out_c.size() ? out_c[i] - out_c[i-1] : -1) != (LockEn ? gap_l[i-1] : gap_n[i-1])) begin
        n_fail++; $display("FAIL lock_gap[%0d]: got %0d want %0d", i, (i < out_c.size() ? out_c[i] - out_c[i-1] : -1), (LockEn ? gap_l[i-1] : gap_n[i-1]));
      end
    end
  endtask

  task automatic test_interleave();
    logic [DW-1:0] a1, b1, a3, b3, got;
    logic [DW-1:0] want[4];
    do_reset();
    a1 = mk(1); b1 = mk(1); a3 = mk(3); b3 = mk(3);
    push_flit(1, a1, 1'b0); push_flit(1, b1, 1'b1);
    push_flit(3, a3, 1'b0); push_flit(3, b3, 1'b1);
    want[0] = a1;
    want[1] = LockEn ? b1 : a3;
    want[2] = LockEn ? a3 : b1;
    want[3] = b3;
    for (int c = 0; c < 14; c++) begin
      step();
      n_tests++; if (data_valid_o !== m_dv || data_o !== m_data) begin n_fail++; $display("FAIL ilv_out: got %b/%h want %b/%h", data_valid_o, data_o, m_dv, m_data); end
    end
    for (int i = 0; i < 4; i++) begin
      got = (i < out_d.size()) ? out_d[i] : 'x;
      n_tests++; if (got !== want[i]) begin n_fail++; $display("FAIL ilv_seq[%0d]: got %h want %h", i, got, want[i]); end
    end
  endtask

  task automatic test_backpressure();
    int guard, n0;
    logic [DW-1:0] got;
    do_reset();
    for (int i = 0; i < 4; i++) push_flit(1, mk(1), i == 3);
    guard = 0;
    while (out_d.size() < 1 && guard < 20) begin step(); guard++; end
    n_tests++; if (out_d.size() < 1) begin n_fail++; $display("FAIL bp_first_timeout: got %0d flits want 1", out_d.size()); end
    avail_drv = 1'b0;
    n0 = out_d.size();
    for (int c = 0; c < 8; c++) begin
      step();
      n_tests++; if (rdy_obs !== rdy_exp) begin n_fail++; $display("FAIL bp_ready: got %b want %b", rdy_obs, rdy_exp); end
      n_tests++; if (data_valid_o !== m_dv) begin n_fail++; $display("FAIL bp_dv: got %b want %b", data_valid_o, m_dv); end
      if (c >= 2) begin
        n_tests++; if (data_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_quiet: got %b want 0", data_valid_o); end
      end
    end
    n_tests++; if (out_d.size() - n0 > 2) begin n_fail++; $display("FAIL bp_overrun: got %0d flits want <=2", out_d.size() - n0); end
    avail_drv = 1'b1;
    guard = 0;
    while (out_d.size() < 4 && guard < 30) begin step(); guard++; end
    for (int c = 0; c < 3; c++) step();
    n_tests++; if (out_d.size() != 4) begin n_fail++; $display("FAIL bp_count: got %0d want 4", out_d.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < out_d.size()) ? out_d[i] : 'x;
      n_tests++; if (got !== sent[1][i]) begin n_fail++; $display("FAIL bp_seq[%0d]: got %h want %h", i, got, sent[1][i]); end
    end
  endtask

  task automatic test_owner_stall();
    bit started;
    int left;
    logic [DW-1:0] got0[$];
    logic [DW-1:0] got;
    do_reset();
    for (int i = 0; i < 3; i++) push_flit(0, mk(0), i == 2);
    push_flit(3, mk(3), 1'b1);
    started = 1'b0;
    left = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      n_tests++; if (grant_o !== onehot(m_owner)) begin n_fail++; $display("FAIL stall_model_grant: got %b want %b", grant_o, onehot(m_owner)); end
      if (left > 0) begin
        n_tests++; if (grant_o !== 4'b0001) begin n_fail++; $display("FAIL stall_grant: got %b want 0001", grant_o); end
        n_tests++; if (rdy_obs[3] !== 1'b0) begin n_fail++; $display("FAIL stall_ready3: got %b want 0", rdy_obs[3]); end
        n_tests++; if (data_valid_o !== 1'b0) begin n_fail++; $display("FAIL stall_dv: got %b want 0", data_valid_o); end
        left--;
        if (left == 0) hold[0] = 1'b0;
      end else if (!started && grant_o === 4'b0001 && count_port(0) >= 1) begin
        started = 1'b1;
        hold[0] = 1'b1;
        left = 5;
      end
    end
    n_tests++; if (!started) begin n_fail++; $display("FAIL stall_never_started: got 0 want 1"); end
    foreach (out_d[i]) if (port_of(out_d[i]) == 0) got0.push_back(out_d[i]);
    for (int i = 0; i < 3; i++) begin
      got = (i < got0.size()) ? got0[i] : 'x;
      n_tests++; if (got !== sent[0][i]) begin n_fail++; $display("FAIL stall_seq[%0d]: got %h want %h", i, got, sent[0][i]); end
    end
    n_tests++; if (count_port(3) != 1) begin n_fail++; $display("FAIL stall_port3: got %0d want 1", count_port(3)); end
  endtask

  task automatic test_random();
    int guard, p, n;
    bit busy;
    logic [DW-1:0] want;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      avail_drv = ($urandom_range(0, 9) != 0);
      for (int k = 0; k < NP; k++) begin
        hold[k] = ($urandom_range(0, 7) == 0);
        if (qd[k].size() < 2 && $urandom_range(0, 3) == 0) begin
          n = $urandom_range(1, 4);
          for (int i = 0; i < n; i++) push_flit(k, mk(k), i == n - 1);
        end
      end
      step();
      n_tests++; if (grant_o !== onehot(m_owner)) begin n_fail++; $display("FAIL rnd_grant@%0d: got %b want %b", cyc, grant_o, onehot(m_owner)); end
      n_tests++; if (data_valid_o !== m_dv) begin n_fail++; $display("FAIL rnd_dv@%0d: got %b want %b", cyc, data_valid_o, m_dv); end
      n_tests++; if (data_o !== m_data) begin n_fail++; $display("FAIL rnd_data@%0d: got %h want %h", cyc, data_o, m_data); end
      n_tests++; if (rdy_obs !== rdy_exp) begin n_fail++; $display("FAIL rnd_ready@%0d: got %b want %b", cyc, rdy_obs, rdy_exp); end
    end
    avail_drv = 1'b1;
    for (int k = 0; k < NP; k++) hold[k] = 1'b0;
    guard = 0;
    busy = 1'b1;
    while (busy && guard < 2000) begin
      step();
      guard++;
      busy = 1'b0;
      for (int k = 0; k < NP; k++) if (qd[k].size() > 0) busy = 1'b1;
    end
    step(); step();
    n_tests++; if (busy) begin n_fail++; $display("FAIL rnd_drain_timeout: got busy want idle"); end
    foreach (out_d[i]) begin
      p = port_of(out_d[i]);
      want = (p < NP && sent[p].size() > 0) ? sent[p].pop_front() : 'x;
      n_tests++; if (out_d[i] !== want) begin n_fail++; $display("FAIL rnd_stream[%0d]: got %h want %h", i, out_d[i], want); end
    end
    for (int k = 0; k < NP; k++) begin
      n_tests++; if (sent[k].size() != 0) begin n_fail++; $display("FAIL rnd_lost[%0d]: got %0d undelivered want 0", k, sent[k].size()); end
    end
  endtask

  initial begin
    rst         = 1'b1;
    avail_i     = 1'b0;
    avail_drv   = 1'b0;
    req_valid_i = '0;
    req_last_i  = '0;
    req_data_i  = '0;
    for (int k = 0; k < NP; k++) hold[k] = 1'b0;
    test_reset();
    test_fairness();
    test_packet_lock();
    test_interleave();
    test_backpressure();
    test_owner_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/noc_inject_arbiter.md
# noc_inject_arbiter

Round-robin arbiter sharing one NoC local injection port among `NumPorts` requesters that speak the standard valid/ready handshake. It converts the winning requester's stream to the NoC avail/valid handshake. The block sits between network-interface sources (FIFOs, DMA engines, CSR responders) and the router local input port. When `NOC_ARB_PACKET_LOCK_EN` is defined, a grant is held for a whole packet, so flits from different sources never interleave.

## Interface
- `NumPorts`, default 4: number of requesters; valid range 1..16.
- `DataWidth`, default 64: flit width in bits.
- `clk`  in  1: single clock; all logic is on its rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `req_data_i`  in  `NumPorts*DataWidth`: packed flits; requester k occupies `[k*DataWidth +: DataWidth]`.
- `req_valid_i`  in  `NumPorts`: requester k has a flit.
- `req_last_i`  in  `NumPorts`: the flit from requester k is the tail of its packet.
- `req_ready_o`  out  `NumPorts`: requester k's flit is accepted this cycle; combinational.
- `data_o`  out  `DataWidth`: flit to the NoC; registered.
- `data_valid_o`  out  1: NoC valid; registered.
- `avail_i`  in  1: NoC available from the router local port.
- `grant_o`  out  `NumPorts`: one-hot current owner; all zero when IDLE; registered.

## Operation
- `avail_q`: `avail_i` registered, reset 0. The NoC side tolerates up to 2 flits after it deasserts avail, so gating on `avail_q` is safe.
- FSM, reset state IDLE:
  - IDLE: if any `req_valid_i` bit is set, pick the first set bit scanning from `rr_ptr` upward, with wrap. Load `owner`, set `grant_o`, go to LOCKED. No flit transfers in IDLE.
  - LOCKED: `req_ready_o[owner] = avail_q`. All other ready bits are 0.
  - Transfer = `req_valid_i[owner] && req_ready_o[owner]`.
  - Transfer with `req_last_i[owner] = 1`: go to IDLE, `rr_ptr <= (owner+1) mod NumPorts`, clear `grant_o`.
  - Otherwise stay in LOCKED.
- Output register:
  - On transfer: `data_valid_o <= 1`, `data_o <= req_data_i[owner]`.
  - Otherwise `data_valid_o <= 0`; `data_o` holds its value.
- `rr_ptr` width is `max(1, clog2(NumPorts))`. Wrap is explicit: `owner == NumPorts-1` gives `rr_ptr = 0`, including non-power-of-2 counts.
- Reset values: `data_valid_o = 0`, `data_o = 0`, `grant_o = 0`, `req_ready_o = 0`, `rr_ptr = 0`, `avail_q = 0`, state IDLE.

## Timing
- Arbitration: 1 cycle. A requester first seen valid in IDLE at cycle t gets `grant_o` at t+1 and can transfer at t+1 if `avail_q = 1`.
- Datapath latency: the flit accepted at cycle t appears on `data_o`/`data_valid_o` at t+1.
- Throughput: 1 flit/cycle within a packet while `avail_i` stays high. There is a 1-cycle bubble between packets (the IDLE cycle).
- `avail_i` falling at cycle t: `avail_q = 0` at t+1, so no transfer from t+1. At most 2 flits reach the NoC after the deassert edge: the flit captured at t-1 and the flit captured at t.
- Owner drops `req_valid_i` mid-packet: the lock is kept, no transfer, `data_valid_o = 0`. Other requesters stay blocked.
- `req_last_i` is only sampled on a transfer. A last flag with valid low or `avail_q = 0` has no effect.
- Simultaneous requests in IDLE: the winner is the lowest index at or above `rr_ptr`. `rr_ptr` moves only on packet completion.
- `rst` mid-packet: all state is cleared the next cycle. The partial packet is abandoned. Recovery is a system-level concern.
- `NumPorts = 1`: identical FSM; `rr_ptr` stays 0.

## Configuration
- `NOC_ARB_PACKET_LOCK_EN` defined: behaviour exactly as above; the grant is held until the tail flit.
- Not defined:
  - Every transfer is treated as a tail (`req_last_i` ignored), so arbitration runs per flit.
  - The FSM still returns to IDLE after each transfer, so there is a 1-cycle bubble per flit.
  - `rr_ptr` advances past the owner after every flit.

## Test plan
- Reset: hold `rst` for 3 cycles with all `req_valid_i = 1` -> all outputs 0; first `grant_o = 4'b0001` on the cycle after `rst` falls.
- Fairness: all 4 requesters send 1-flit packets continuously, `avail_i = 1` -> grant order 0,1,2,3,0; one flit every 2 cycles on `data_o`, with payload equal to the requester index.
- Packet lock (macro defined): port 2 sends a 3-flit packet `A,B,C` (last on C) while port 0 is valid -> `data_o` shows `A,B,C` on consecutive cycles; port 0's flit follows after a 1-cycle gap.
- Backpressure: drop `avail_i` after flit 1 of a 4-flit packet -> at most 2 flits appear after the deassert edge, then `data_valid_o = 0` until `avail_i` returns; no flit is lost or duplicated.
- Owner stall: the owner deasserts valid for 5 cycles mid-packet while port 3 is valid -> `grant_o` unchanged, port 3 ready stays 0, packet resumes intact.
- Macro undefined: ports 1 and 3 each send 2-flit packets -> `data_o` interleaves 1a,3a,1b,3b.
